// File: rtl/wb_pkg.sv
// Shared widths and the write-request record for the register-file writeback path.
package wb_pkg;

  localparam int XLEN       = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

  // A register is busy while a load to it is outstanding, sitting in the skid,
  // or presented on the regfile port but not yet written.
  function automatic logic reg_busy(
    input logic [REG_ADDR_W-1:0] q,
    input logic [NUM_REGS-1:0]   pend,
    input logic [REG_ADDR_W-1:0] rd_addr,
    input logic                  skid_full,
    input logic [REG_ADDR_W-1:0] skid_rd
  );
    return (q != '0) && (pend[q] || (rd_addr == q) || (skid_full && (skid_rd == q)));
  endfunction

endpackage

// File: rtl/wb_skid_entry.sv
// Single-entry holding register for a load that lost arbitration to an ALU result.
// Push and pop together while full is never requested by the top.
module wb_skid_entry
  import wb_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    push,
  input  logic    pop,
  input  wb_req_t d,
  output logic    full,
  output wb_req_t q
);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full <= 1'b0;
      q    <= '0;
    end else if (push) begin
      full <= 1'b1;
      q    <= d;
    end else if (pop) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Arbitrates ALU and load results onto the regfile write port (ALU > skid > new load),
// one registered stage to o_rd_*; tracks in-flight loads per register for issue stalls.
module writeback_unit
  import wb_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_alu_valid,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [REG_ADDR_W-1:0] i_ld_rd,
  input  logic [XLEN-1:0]       i_ld_data,
  input  logic                  i_iss_ld,
  input  logic [REG_ADDR_W-1:0] i_iss_rd,
  input  logic [REG_ADDR_W-1:0] i_q_rs1,
  input  logic [REG_ADDR_W-1:0] i_q_rs2,
  output logic                  o_rs1_busy,
  output logic                  o_rs2_busy,
  output logic [REG_ADDR_W-1:0] o_rd_addr,
  output logic [XLEN-1:0]       o_rd_data
);

  logic                skid_push;
  logic                skid_pop;
  logic                skid_full;
  wb_req_t             skid_q;
  wb_req_t             ld_req;
  wb_req_t             sel_req;
  logic                sel_vld;
  logic                sel_is_ld;
  logic                alu_live;
  logic                ld_live;
  logic [NUM_REGS-1:0] pend;
  logic [NUM_REGS-1:0] pend_nxt;

  // Ready depends only on registered state so upstream never sees a comb loop.
  assign o_ld_ready = !i_rst && !skid_full;

  assign ld_req.rd   = i_ld_rd;
  assign ld_req.data = i_ld_data;

  always_comb begin
    // rd=0 results complete their handshake but are dropped here.
    alu_live  = i_alu_valid && (i_alu_rd != '0);
    ld_live   = i_ld_valid && o_ld_ready && (i_ld_rd != '0);
    skid_push = 1'b0;
    skid_pop  = 1'b0;
    sel_vld   = 1'b0;
    sel_is_ld = 1'b0;
    sel_req   = '0;
    if (alu_live) begin
      sel_vld      = 1'b1;
      sel_req.rd   = i_alu_rd;
      sel_req.data = i_alu_data;
      skid_push    = ld_live;
    end else if (skid_full) begin
      sel_vld   = 1'b1;
      sel_is_ld = 1'b1;
      sel_req   = skid_q;
      skid_pop  = 1'b1;
    end else if (ld_live) begin
      sel_vld   = 1'b1;
      sel_is_ld = 1'b1;
      sel_req   = ld_req;
    end
  end

  always_comb begin
    pend_nxt = pend;
    if (sel_is_ld) pend_nxt[sel_req.rd] = 1'b0;
    // A re-issue in the commit cycle must keep the register busy.
    if (i_iss_ld && (i_iss_rd != '0)) pend_nxt[i_iss_rd] = 1'b1;
  end

  wb_skid_entry u_skid (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (skid_push),
    .pop   (skid_pop),
    .d     (ld_req),
    .full  (skid_full),
    .q     (skid_q)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rd_addr <= '0;
      o_rd_data <= '0;
      pend      <= '0;
    end else begin
      pend <= pend_nxt;
      if (sel_vld) begin
        o_rd_addr <= sel_req.rd;
        o_rd_data <= sel_req.data;
      end else begin
        o_rd_addr <= '0;
      end
    end
  end

  assign o_rs1_busy = reg_busy(i_q_rs1, pend, o_rd_addr, skid_full, skid_q.rd);
  assign o_rs2_busy = reg_busy(i_q_rs2, pend, o_rd_addr, skid_full, skid_q.rd);

endmodule
